dffram_bist: RTL and testbench
==============================

# dffram_bist

Synthesizable built-in self-test controller that acts as the initiator on a single DFFRAM port (CLK/EN0/WE0/A0/Di0/Do0). It runs a March C- sequence over every word and reports pass/fail with the first failing address and data. It sits between SoC test logic and a DFFRAM macro such as DFFRAM512x32, muxed in ahead of the functional port.

## Interface
- WSIZE, 4, byte lanes per word; data width is WSIZE*8
- AWIDTH, 9, word address width; N = 2^AWIDTH words
- RD_LAT, 1, cycles from read issue until Do0 is valid, ≥1
- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  level-sampled only in IDLE; begins a run
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last completed run; cleared at start
- fail_addr  out  AWIDTH  address of first mismatch
- fail_data  out  WSIZE*8  Do0 value captured at first mismatch
- EN0  out  1  RAM enable
- WE0  out  WSIZE  RAM byte write enables
- A0  out  AWIDTH  RAM address
- Di0  out  WSIZE*8  RAM write data
- Do0  in  WSIZE*8  RAM read data

## Operation
- March elements, in order: E0 ⇑(w0); E1 ⇑(r0,w1); E2 ⇑(r1,w0); E3 ⇓(r0,w1); E4 ⇓(r1,w0); E5 ⇑(r0). 0 is all-zeros and 1 is all-ones; writes use WE0 all ones.
- ⇑ means addresses 0..N-1; ⇓ means N-1..0. The address counter wraps to the element's start address at an element boundary.
- FSM states: IDLE, WRITE, READ, WAIT, DONE.
  - IDLE with start=1 → go to first op of E0; pass and fail_* are cleared.
  - WRITE: EN0=1, WE0=mask, A0, Di0 driven for one cycle.
  - READ: EN0=1, WE0=0 for one cycle, then WAIT for RD_LAT cycles with EN0=0 and A0 held.
  - Compare Do0 with the expected value at the clock edge that ends the last WAIT cycle.
  - Mismatch → capture A0 into fail_addr and Do0 into fail_data, set pass=0, go to DONE. The run aborts on the first failure.
  - All elements complete without a mismatch → pass=1, go to DONE.
  - DONE lasts one cycle (done=1), then returns to IDLE. If start is still high, a new run begins on the next cycle.
- start while busy is ignored.
- Outside WRITE and READ: EN0=0, WE0=0, and Di0/A0 hold their last value.

## Timing
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, EN0=0, WE0=0, A0=0, Di0=0, FSM in IDLE.
- RST asserted mid-run: all outputs return to their reset values immediately (asynchronous), and no further RAM cycles occur.
- busy rises in the cycle after start is sampled and falls in the DONE cycle.
- Per-address cost: w = 1 cycle; r = 1+RD_LAT cycles; (r,w) = 2+RD_LAT cycles.
- Total RAM-op cycles with a passing run and the macro off: N + 4N(2+RD_LAT) + N(1+RD_LAT). With RD_LAT=1 this is 15N (7680 for N=512), followed by one DONE cycle.

## Configuration
- DFFRAM_BIST_BYTE_EN defined: element E6 ⇑ is appended after E5. For each address, for lane k = 0..WSIZE-1:
  - write all-ones with WE0 = 1<<k;
  - read and expect lanes 0..k = 0xFF and the remaining lanes = 0x00.
  - Cost is WSIZE(2+RD_LAT) cycles per address (12N for defaults). Memory ends all-ones.
- DFFRAM_BIST_BYTE_EN undefined: the run ends after E5 and memory ends all-zeros.

## Structure
- Package dffram_bist_pkg holds:
  - the state enum;
  - the march element descriptor typedef (direction, op count, per-op read/write, data background);
  - the constant element table.
- Sub-module dffram_bist_addr_gen: an up/down address counter with load-to-start, step, and a last-address flag.

## Test plan
- Reset: hold RST for 3 cycles → every output at its reset value; EN0=0 throughout.
- Good RAM (DFFRAM512x32 or a behavioral model, RD_LAT=1, macro off): one-cycle start pulse → done exactly 7680 cycles after busy rises; pass=1; every word reads 0x00000000 afterwards.
- Behavioral model with bit 5 stuck-at-1 at address 0x1F2 → abort in E1; pass=0, fail_addr=0x1F2, fail_data=0x00000020.
- RST pulsed at cycle 100 of a run → EN0 and busy drop without waiting for a clock edge. A following start → full run completes with pass=1.
- DFFRAM_BIST_BYTE_EN defined, model ignoring WE0[2] at address 0x010 → pass=0, fail_addr=0x010, fail_data=0x0000FFFF. On a good RAM, done arrives after 13824 cycles with pass=1.
- start pulsed while busy → no effect on the run or its cycle count. start held high → a second run starts in the cycle after DONE.

Source files
------------

// File: rtl/dffram_bist_pkg.sv
// dffram_bist_pkg -- shared types and constants for the DFFRAM March C- BIST.
//
// Contents:
//   state_t       controller FSM states
//   march_elem_t  descriptor of one march element (direction, op count,
//                 per-op read/write kind, per-op data background, lane walk)
//   MARCH_TABLE   constant element table, executed in index order
//   NUM_ELEM      number of table entries used in this build
//   op_state      maps an element/op pair onto the FSM state issuing it
//
// Build option: DFFRAM_BIST_BYTE_EN appends the byte-lane walk element E6.
package dffram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic       up;         // 1: addresses 0..N-1, 0: N-1..0
    logic       two_ops;    // element has a second op per address
    logic       lane_walk;  // repeat the op pair once per byte lane
    logic [1:0] is_write;   // bit i set: op i is a write
    logic [1:0] data_ones;  // bit i set: op i uses the all-ones background
  } march_elem_t;

  localparam int ELEM_W = 3;

  // The lane-walk entry is always present; NUM_ELEM decides whether the
  // controller ever reaches it.
  localparam march_elem_t MARCH_TABLE [7] = '{
    '{up: 1'b1, two_ops: 1'b0, lane_walk: 1'b0, is_write: 2'b01, data_ones: 2'b00}, // E0 up   (w0)
    '{up: 1'b1, two_ops: 1'b1, lane_walk: 1'b0, is_write: 2'b10, data_ones: 2'b10}, // E1 up   (r0,w1)
    '{up: 1'b1, two_ops: 1'b1, lane_walk: 1'b0, is_write: 2'b10, data_ones: 2'b01}, // E2 up   (r1,w0)
    '{up: 1'b0, two_ops: 1'b1, lane_walk: 1'b0, is_write: 2'b10, data_ones: 2'b10}, // E3 down (r0,w1)
    '{up: 1'b0, two_ops: 1'b1, lane_walk: 1'b0, is_write: 2'b10, data_ones: 2'b01}, // E4 down (r1,w0)
    '{up: 1'b1, two_ops: 1'b0, lane_walk: 1'b0, is_write: 2'b00, data_ones: 2'b00}, // E5 up   (r0)
    '{up: 1'b1, two_ops: 1'b1, lane_walk: 1'b1, is_write: 2'b01, data_ones: 2'b11}  // E6 up   lane walk (w1,r)
  };

`ifdef DFFRAM_BIST_BYTE_EN
  localparam int NUM_ELEM = 7;
`else
  localparam int NUM_ELEM = 6;
`endif

  function automatic state_t op_state(input march_elem_t e, input logic op);
    return e.is_write[op] ? ST_WRITE : ST_READ;
  endfunction

endpackage

// File: rtl/dffram_bist_addr_gen.sv
// dffram_bist_addr_gen -- up/down word address counter for the march engine.
//
// Ports:
//   CLK, RST   clock, asynchronous active-high reset (address returns to 0)
//   load       load the start address of a new element
//   load_up    direction of the element being loaded (start at 0 or N-1)
//   step       advance one address in direction 'up'
//   up         direction of the element currently running
//   addr       current word address
//   last       addr is the final address of the current direction
module dffram_bist_addr_gen #(
  parameter int AWIDTH = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              load_up,
  input  logic              step,
  input  logic              up,
  output logic [AWIDTH-1:0] addr,
  output logic              last
);

  logic [AWIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_up ? '0 : '1;
    end else if (step) begin
      addr_d = up ? addr_q + AWIDTH'(1) : addr_q - AWIDTH'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign last = up ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/dffram_bist.sv
// dffram_bist -- March C- built-in self-test controller for one DFFRAM port.
//
// Runs E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0);
// E5 up(r0) over every word, aborting on the first read mismatch.
// Build option: DFFRAM_BIST_BYTE_EN appends E6, a per-address byte-lane
// walk (write all-ones with one lane enabled, then read back).
//
// Parameters: WSIZE byte lanes per word, AWIDTH word address width,
//             RD_LAT cycles from read issue to valid Do0 (>= 1).
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   start             begins a run when sampled in IDLE
//   busy              run in progress (op states)
//   done              one-cycle end-of-run pulse
//   pass              result of the last completed run
//   fail_addr/data    address and read data of the first mismatch
//   EN0/WE0/A0/Di0    RAM command outputs
//   Do0               RAM read data
module dffram_bist
  import dffram_bist_pkg::*;
#(
  parameter int WSIZE  = 4,
  parameter int AWIDTH = 9,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [AWIDTH-1:0]    fail_addr,
  output logic [WSIZE*8-1:0]   fail_data,
  output logic                 EN0,
  output logic [WSIZE-1:0]     WE0,
  output logic [AWIDTH-1:0]    A0,
  output logic [WSIZE*8-1:0]   Di0,
  input  logic [WSIZE*8-1:0]   Do0
);

  localparam int DW     = WSIZE * 8;
  localparam int LANE_W = (WSIZE > 1) ? $clog2(WSIZE) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WSIZE - 1);

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic                op_q, op_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                pass_q, pass_d;
  logic [AWIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DW-1:0]       fail_data_q, fail_data_d;
  logic [DW-1:0]       di_q, di_d;

  logic                addr_load, addr_load_up, addr_step, addr_last, advance;
  logic [AWIDTH-1:0]   addr;
  march_elem_t         cur_elem;
  logic [DW-1:0]       wr_data, exp_data;
  logic [WSIZE-1:0]    wr_mask;

  dffram_bist_addr_gen #(.AWIDTH(AWIDTH)) u_addr_gen (
    .CLK     (CLK),
    .RST     (RST),
    .load    (addr_load),
    .load_up (addr_load_up),
    .step    (addr_step),
    .up      (cur_elem.up),
    .addr    (addr),
    .last    (addr_last)
  );

  // Data path of the current op. In the lane walk the expected word grows
  // one byte of ones per lane written so far (lanes 0..lane_q).
  always_comb begin
    cur_elem = MARCH_TABLE[elem_q];
    wr_data  = cur_elem.data_ones[op_q] ? {DW{1'b1}} : {DW{1'b0}};
    wr_mask  = cur_elem.lane_walk ? (WSIZE'(1) << lane_q) : {WSIZE{1'b1}};
    for (int b = 0; b < WSIZE; b++) begin
      exp_data[b*8 +: 8] = (cur_elem.lane_walk ? (b <= int'(lane_q))
                                               : cur_elem.data_ones[op_q]) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    // NOTE: defaults first -- every path assigns every signal, so no latches.
    state_d      = state_q;
    elem_d       = elem_q;
    op_d         = op_q;
    lane_d       = lane_q;
    wait_d       = wait_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    di_d         = di_q;
    addr_load    = 1'b0;
    addr_load_up = 1'b1;
    addr_step    = 1'b0;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          elem_d       = '0;
          op_d         = 1'b0;
          lane_d       = '0;
          addr_load    = 1'b1;
          addr_load_up = MARCH_TABLE[0].up;
          state_d      = op_state(MARCH_TABLE[0], 1'b0);
        end
      end
      ST_WRITE: begin
        di_d    = wr_data;
        advance = 1'b1;
      end
      ST_READ: begin
        wait_d  = WAIT_W'(RD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (Do0 != exp_data) begin
          fail_addr_d = addr;
          fail_data_d = Do0;
          pass_d      = 1'b0;
          state_d     = ST_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Sequencing order: next op of this address, next lane, next address,
    // next element, end of run.
    if (advance) begin
      if (cur_elem.two_ops && !op_q) begin
        op_d    = 1'b1;
        state_d = op_state(cur_elem, 1'b1);
      end else if (cur_elem.lane_walk && lane_q != LAST_LANE) begin
        op_d    = 1'b0;
        lane_d  = lane_q + LANE_W'(1);
        state_d = op_state(cur_elem, 1'b0);
      end else if (!addr_last) begin
        op_d      = 1'b0;
        lane_d    = '0;
        addr_step = 1'b1;
        state_d   = op_state(cur_elem, 1'b0);
      end else if (elem_q != LAST_ELEM) begin
        op_d         = 1'b0;
        lane_d       = '0;
        elem_d       = elem_q + ELEM_W'(1);
        addr_load    = 1'b1;
        addr_load_up = MARCH_TABLE[elem_q + ELEM_W'(1)].up;
        state_d      = op_state(MARCH_TABLE[elem_q + ELEM_W'(1)], 1'b0);
      end else begin
        pass_d  = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      op_q        <= 1'b0;
      lane_q      <= '0;
      wait_q      <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      di_q        <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      wait_q      <= wait_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      di_q        <= di_d;
    end
  end

  // RAM strobes are decoded from the state register so an asynchronous
  // reset removes them immediately; Di0 holds the last written word.
  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign EN0       = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign WE0       = (state_q == ST_WRITE) ? wr_mask : '0;
  assign A0        = addr;
  assign Di0       = (state_q == ST_WRITE) ? wr_data : di_q;

endmodule

// File: tb/tb_dffram_bist.sv
// tb_dffram_bist -- scoreboard bench for dffram_bist with a behavioural
// DFFRAM model (RD_LAT = 1) supporting stuck-at bits and a broken
// partial-write byte enable. Expected results come from an array-based
// march reference model; a monitor compares them at every done pulse.
module tb_dffram_bist;

  localparam int WSIZE  = 4;
  localparam int AWIDTH = 9;
  localparam int RD_LAT = 1;
  localparam int DW     = WSIZE * 8;
  localparam int N      = 1 << AWIDTH;
  localparam logic [DW-1:0] ONES = '1;

  typedef struct {
    bit                pass;
    logic [AWIDTH-1:0] addr;
    logic [DW-1:0]     data;
    int                cycles;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, pass, EN0;
  logic [AWIDTH-1:0] fail_addr, A0;
  logic [DW-1:0]     fail_data, Di0;
  logic [WSIZE-1:0]  WE0;
  logic [DW-1:0]     do_q = '0;

  logic [DW-1:0]     ram   [N];
  logic [DW-1:0]     mem_m [N];
  logic              fill_go = 1'b0;

  // Fault configuration shared by the RAM model and the reference model.
  int                sa_addr = -1;
  logic [DW-1:0]     sa1 = '0;
  logic [DW-1:0]     sa0 = '0;
  int                we_addr = -1;
  int                we_lane = 0;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  int   busy_cnt = 0;

  dffram_bist #(.WSIZE(WSIZE), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .EN0       (EN0),
    .WE0       (WE0),
    .A0        (A0),
    .Di0       (Di0),
    .Do0       (do_q)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
    if (a == sa_addr) return (v | sa1) & ~sa0;
    return v;
  endfunction

  // Broken byte enable: lane we_lane at we_addr is dropped on partial writes.
  function automatic bit lane_ok(input int a, input int k, input logic [WSIZE-1:0] mask);
    return !(a == we_addr && k == we_lane && mask != '1);
  endfunction

  always @(posedge CLK) begin
    if (fill_go) begin
      for (int a = 0; a < N; a++) ram[a] <= $urandom;
    end else if (EN0) begin
      if (WE0 != '0) begin
        for (int k = 0; k < WSIZE; k++)
          if (WE0[k] && lane_ok(int'(A0), k, WE0)) ram[A0][8*k +: 8] <= Di0[8*k +: 8];
      end else begin
        do_q <= rd_fault(int'(A0), ram[A0]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic m_write(input int a, input logic [DW-1:0] v, input logic [WSIZE-1:0] mask);
    for (int k = 0; k < WSIZE; k++)
      if (mask[k] && lane_ok(a, k, mask)) mem_m[a][8*k +: 8] = v[8*k +: 8];
  endtask

  task automatic m_elem(inout exp_t x, input bit up, input bit rd, input logic [DW-1:0] rv,
                        input bit wr, input logic [DW-1:0] wv);
    int a;
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      if (!x.pass) return;
      a = up ? i : N - 1 - i;
      if (rd) begin
        x.cycles += 1 + RD_LAT;
        v = rd_fault(a, mem_m[a]);
        if (v != rv) begin
          x.pass = 0; x.addr = AWIDTH'(a); x.data = v;
          return;
        end
      end
      if (wr) begin
        x.cycles += 1;
        m_write(a, wv, '1);
      end
    end
  endtask

  task automatic m_lane_walk(inout exp_t x);
    logic [DW-1:0] v, e;
    for (int a = 0; a < N; a++) begin
      for (int k = 0; k < WSIZE; k++) begin
        if (!x.pass) return;
        x.cycles += 1;
        m_write(a, ONES, WSIZE'(1) << k);
        x.cycles += 1 + RD_LAT;
        for (int b = 0; b < WSIZE; b++) e[8*b +: 8] = (b <= k) ? 8'hFF : 8'h00;
        v = rd_fault(a, mem_m[a]);
        if (v != e) begin
          x.pass = 0; x.addr = AWIDTH'(a); x.data = v;
          return;
        end
      end
    end
  endtask

  task automatic model_run(input bit reload, output exp_t x);
    if (reload) for (int a = 0; a < N; a++) mem_m[a] = ram[a];
    x.pass = 1; x.addr = '0; x.data = '0; x.cycles = 0;
    m_elem(x, 1, 0, '0,   1, '0);    // E0
    m_elem(x, 1, 1, '0,   1, ONES);  // E1
    m_elem(x, 1, 1, ONES, 1, '0);    // E2
    m_elem(x, 0, 1, '0,   1, ONES);  // E3
    m_elem(x, 0, 1, ONES, 1, '0);    // E4
    m_elem(x, 1, 1, '0,   0, '0);    // E5
`ifdef DFFRAM_BIST_BYTE_EN
    m_lane_walk(x);                  // E6
`endif
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got a done pulse, expected none");
          end else begin
            e = sb.pop_front();
            check("pass",         64'(pass),      64'(e.pass));
            check("fail_addr",    64'(fail_addr), 64'(e.addr));
            check("fail_data",    64'(fail_data), 64'(e.data));
            check("run_cycles",   64'(busy_cnt),  64'(e.cycles));
            check("busy_at_done", 64'(busy),      64'(0));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_faults();
    sa_addr = -1; sa1 = '0; sa0 = '0; we_addr = -1; we_lane = 0;
  endtask

  task automatic fill_ram();
    @(negedge CLK) fill_go = 1'b1;
    @(negedge CLK) fill_go = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic queue_run();
    exp_t e;
    fill_ram();
    model_run(1, e);
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40000 && sb.size() != 0; i++) @(negedge CLK);
    check(name, 64'(sb.size()), 64'(0));
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    int   bad, gap, bitn;
    logic [DW-1:0] one;

    // Reset: three cycles held, EN0 low throughout, every output at reset value.
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("en0_in_reset", 64'(EN0), 64'(0));
    end
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_done",      64'(done),      64'(0));
    check("rst_pass",      64'(pass),      64'(0));
    check("rst_fail_addr", 64'(fail_addr), 64'(0));
    check("rst_fail_data", 64'(fail_data), 64'(0));
    check("rst_we0",       64'(WE0),       64'(0));
    check("rst_a0",        64'(A0),        64'(0));
    check("rst_di0",       64'(Di0),       64'(0));
    RST = 1'b0;
    @(negedge CLK);

    // Good RAM; a start pulse during the run must change nothing.
    clear_faults();
    queue_run();
    pulse_start();
    repeat (50) @(negedge CLK);
    pulse_start();
    drain("good_run_drain");
    bad = 0;
    for (int a = 0; a < N; a++) if (ram[a] !== mem_m[a]) bad++;
    check("mem_final_bad_words", 64'(bad), 64'(0));

    // Bit 5 stuck-at-1 at 0x1F2.
    clear_faults();
    sa_addr = 'h1F2; sa1 = 32'h0000_0020;
    queue_run();
    pulse_start();
    drain("stuck_bit5_drain");

    // Random stuck-at fault.
    clear_faults();
    one = 1;
    sa_addr = $urandom_range(0, N - 1);
    bitn = $urandom_range(0, DW - 1);
    if ($urandom_range(0, 1) == 1) sa1 = one << bitn;
    else                           sa0 = one << bitn;
    queue_run();
    pulse_start();
    drain("rand_stuck_drain");

    // Asynchronous reset at cycle 100 of a run.
    clear_faults();
    fill_ram();
    pulse_start();
    for (int i = 0; i < 10 && !busy; i++) @(negedge CLK);
    repeat (100) @(negedge CLK);
    @(posedge CLK);
    #2;
    check("en0_before_rst", 64'(EN0), 64'(1));
    RST = 1'b1;
    #1;
    check("async_rst_en0",  64'(EN0),  64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_we0",  64'(WE0),  64'(0));
    check("async_rst_a0",   64'(A0),   64'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // start held high: two back-to-back passing runs.
    queue_run();
    model_run(0, e);
    sb.push_back(e);
    @(negedge CLK) start = 1'b1;
    for (int i = 0; i < 40000 && !done; i++) @(negedge CLK);
    check("held_first_done", 64'(done), 64'(1));
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (!busy && gap < 10);
    check("held_restart_gap", 64'(gap), 64'(2));
    start = 1'b0;
    drain("held_start_drain");

`ifdef DFFRAM_BIST_BYTE_EN
    // Partial-write byte enable for lane 2 broken at 0x010.
    clear_faults();
    we_addr = 'h010; we_lane = 2;
    queue_run();
    pulse_start();
    drain("byte_en_fault_drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
